// File: rtl/pi_slot_arbiter.sv
// Pi bus slot arbiter: grants each select window to one requester by
// round-robin, drives the memory address/data/write-enable for that slot,
// issues a single memory strobe and acknowledges the requester at slot end.
module pi_slot_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                             clk16,
  input  logic                             reset,
  input  logic                             slot_select,
  input  logic                             slot_enable,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               ack,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  output logic                             mem_we,
  output logic                             mem_strobe,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic                             busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_EN = 2'd1,
    STROBED = 2'd2
  } state_t;

  state_t             state;
  logic               sel_q;
  logic               en_q;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gnt;
  logic [IDX_W-1:0]   rr_next;

  logic               sel_rise;
  logic               sel_fall;
  logic               en_rise;
  logic               en_fall;
  logic [NUM_REQ-1:0] elig;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   scan_idx;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [DATA_WIDTH-1:0] pick_wdata;
  logic               pick_we;

  assign sel_rise = slot_select & ~sel_q;
  assign sel_fall = ~slot_select & sel_q;
  assign en_rise  = slot_enable & ~en_q;
  assign en_fall  = ~slot_enable & en_q;

  // A requester being acknowledged this cycle is not eligible again yet
  assign elig = req & ~ack;

  // Pointer advances past the requester that was just served
  assign rr_next = (gnt == IDX_W'(NUM_REQ - 1)) ? '0 : gnt + IDX_W'(1);

  // Window edge detection registers
  always_ff @(posedge clk16 or posedge reset) begin
    if (reset) begin
      sel_q <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      sel_q <= slot_select;
      en_q  <= slot_enable;
    end
  end

  // Round-robin scan starting at rr_ptr, ascending with wrap
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    pick_addr  = '0;
    pick_wdata = '0;
    pick_we    = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!pick_found && elig[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
        pick_addr  = req_addr[scan_idx*ADDR_WIDTH +: ADDR_WIDTH];
        pick_wdata = req_wdata[scan_idx*DATA_WIDTH +: DATA_WIDTH];
        pick_we    = req_we[scan_idx];
      end
    end
  end

  // Slot state machine with registered memory-side and requester-side outputs
  always_ff @(posedge clk16 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt        <= '0;
      ack        <= '0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_strobe <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ack        <= '0;
      mem_strobe <= 1'b0;

      // Pointer moves in the ack cycle so a grant in that same cycle uses the old value
      if (|ack) begin
        rr_ptr <= rr_next;
      end

      case (state)
        IDLE: begin
          if (sel_rise && pick_found) begin
            gnt       <= pick_idx;
            mem_addr  <= pick_addr;
            mem_wdata <= pick_wdata;
            mem_we    <= pick_we;
            busy      <= 1'b1;
            state     <= WAIT_EN;
          end
        end

        WAIT_EN: begin
          if (sel_fall) begin
            // Window closed before the strobe: request remains pending
            busy  <= 1'b0;
            state <= IDLE;
          end else if (en_rise) begin
            mem_strobe <= 1'b1;
            state      <= STROBED;
          end
        end

        STROBED: begin
          if (en_fall && !mem_we) begin
            rdata <= mem_rdata;
          end
          if (sel_fall) begin
            ack   <= NUM_REQ'(1) << gnt;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pi_slot_arbiter.sv
// Self-checking bench for pi_slot_arbiter: directed slot scenarios followed by
// randomized windows, scored against a transaction-level round-robin model.
module tb_pi_slot_arbiter;

  localparam int N  = 3;
  localparam int AW = 17;
  localparam int DW = 8;

  logic            clk16 = 1'b0;
  logic            reset;
  logic            slot_select;
  logic            slot_enable;
  logic [N-1:0]    req;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_we;
  logic            mem_strobe;
  logic [DW-1:0]   mem_rdata;
  logic            busy;

  pi_slot_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk16       (clk16),
    .reset       (reset),
    .slot_select (slot_select),
    .slot_enable (slot_enable),
    .req         (req),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .ack         (ack),
    .rdata       (rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_strobe  (mem_strobe),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  always #5 clk16 = ~clk16;

  int total = 0;
  int bad   = 0;

  // Requester-side model state
  bit            pending [N];
  logic          we_m    [N];
  logic [AW-1:0] addr_m  [N];
  logic [DW-1:0] wd_m    [N];
  int            rr_m    = 0;
  logic [DW-1:0] last_rd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req[i]                 = pending[i];
      req_we[i]              = we_m[i];
      req_addr[i*AW +: AW]   = addr_m[i];
      req_wdata[i*DW +: DW]  = wd_m[i];
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pending[i] = 1'b1;
    we_m[i]    = we;
    addr_m[i]  = a;
    wd_m[i]    = d;
  endtask

  task automatic set_rand_req(input int i);
    set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"},    32'(ack), 32'd0);
    check({tag, "_rdata"},  32'(rdata), 32'd0);
    check({tag, "_maddr"},  32'(mem_addr), 32'd0);
    check({tag, "_mwdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_mctl"},   {30'd0, mem_we, mem_strobe}, 32'd0);
    check({tag, "_busy"},   32'(busy), 32'd0);
  endtask

  // Reset pulse between slots; optionally withdraw all requests while in reset
  task automatic pulse_reset(input bit clear);
    @(posedge clk16); #1;
    reset = 1'b1;
    slot_select = 1'b0;
    slot_enable = 1'b0;
    if (clear) begin
      for (int i = 0; i < N; i++) pending[i] = 1'b0;
    end
    drive_req();
    @(negedge clk16);
    check_outputs_zero("rst");
    @(posedge clk16); #1;
    reset   = 1'b0;
    rr_m    = 0;
    last_rd = '0;
  endtask

  // One quiet cycle in which idle requesters may raise new random requests
  task automatic prep_random();
    @(posedge clk16); #1;
    slot_select = 1'b0;
    slot_enable = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!pending[i] && $urandom_range(0, 1) == 1) set_rand_req(i);
    end
    drive_req();
  endtask

  // One select window of s_len cycles plus three trailing low cycles.
  // Enable spans [2, s_len-3], or [2, s_len-1] when en_tail (falls with select).
  task automatic run_window(input int s_len, input bit has_en, input logic [N-1:0] late_mask,
                            input bit rst_mid, input logic [DW-1:0] rd_val, input bit en_tail);
    int            win;
    int            c;
    int            en_lo;
    int            en_hi;
    int            strobes;
    int            strobe_at;
    int            acks;
    int            ack_at;
    logic [N-1:0]  ack_seen;
    logic [DW-1:0] rd_seen;
    logic [AW-1:0] sa;
    logic [DW-1:0] swd;
    logic          swe;
    logic [AW-1:0] got_a;
    logic [DW-1:0] got_d;
    logic          got_we;
    bit            served;
    logic [DW-1:0] exp_rd;

    win = -1; strobes = 0; strobe_at = -1; acks = 0; ack_at = -1;
    ack_seen = '0; rd_seen = '0; sa = '0; swd = '0; swe = 1'b0;
    got_a = '0; got_d = '0; got_we = 1'b0;
    en_lo = 2;
    en_hi = en_tail ? s_len - 1 : s_len - 3;
    mem_rdata = rd_val;

    for (int k = 0; k < s_len + 3; k++) begin
      @(posedge clk16); #1;
      slot_select = (k < s_len);
      slot_enable = has_en && (k >= en_lo) && (k <= en_hi);
      if (k == 0) begin
        for (int j = 0; j < N; j++) begin
          c = (rr_m + j) % N;
          if (win < 0 && pending[c]) win = c;
        end
        if (win >= 0) begin
          sa = addr_m[win]; swd = wd_m[win]; swe = we_m[win];
        end
      end
      if (k == 1) begin
        for (int i = 0; i < N; i++) begin
          if (late_mask[i] && !pending[i]) set_rand_req(i);
          else if (pending[i] && $urandom_range(0, 1) == 1) begin
            addr_m[i] = AW'($urandom);
            wd_m[i]   = DW'($urandom);
          end
        end
        if (rst_mid) reset = 1'b1;
      end
      if (rst_mid && k == s_len + 1) reset = 1'b0;
      drive_req();

      @(negedge clk16);
      if (mem_strobe) begin
        strobes++; strobe_at = k;
        got_a = mem_addr; got_d = mem_wdata; got_we = mem_we;
      end
      if (ack != '0) begin
        acks++; ack_at = k; ack_seen = ack; rd_seen = rdata;
        for (int i = 0; i < N; i++) if (ack[i]) pending[i] = 1'b0;
      end
      if (k == 1) begin
        if (rst_mid) check_outputs_zero("midrst");
        else         check("busy_grant", 32'(busy), 32'(win >= 0));
      end
      if (k == s_len + 1) check("busy_end", 32'(busy), 32'd0);
    end

    served = (win >= 0) && has_en && !rst_mid;
    check("strobe_cnt", 32'(strobes), served ? 32'd1 : 32'd0);
    check("ack_cnt",    32'(acks),    served ? 32'd1 : 32'd0);
    if (served) begin
      check("strobe_at", 32'(strobe_at), 32'(en_lo + 1));
      check("mem_addr",  32'(got_a),  32'(sa));
      check("mem_we",    32'(got_we), 32'(swe));
      if (swe) check("mem_wdata", 32'(got_d), 32'(swd));
      check("ack_at",    32'(ack_at), 32'(s_len + 1));
      check("ack_vec",   32'(ack_seen), 32'd1 << win);
      exp_rd = swe ? last_rd : rd_val;
      check("rdata",     32'(rd_seen), 32'(exp_rd));
      last_rd = exp_rd;
      rr_m    = (win + 1) % N;
    end
    if (rst_mid) begin
      rr_m    = 0;
      last_rd = '0;
    end
  endtask

  initial begin
    reset       = 1'b1;
    slot_select = 1'b0;
    slot_enable = 1'b0;
    mem_rdata   = '0;
    for (int i = 0; i < N; i++) begin
      pending[i] = 1'b0; we_m[i] = 1'b0; addr_m[i] = '0; wd_m[i] = '0;
    end
    drive_req();
    repeat (3) @(posedge clk16);
    @(negedge clk16);
    check_outputs_zero("por");
    @(posedge clk16); #1;
    reset = 1'b0;

    // Idle windows with nobody requesting
    repeat (3) run_window(6, 1'b1, '0, 1'b0, DW'($urandom), 1'b0);

    // Single read
    set_req(0, 1'b0, 17'h12345, 8'h00);
    run_window(7, 1'b1, '0, 1'b0, 8'hA5, 1'b0);
    check("t2_rdata", 32'(rdata), 32'h0000_00A5);

    // Two held requesters alternate 0,1,0,1
    pulse_reset(1'b1);
    set_req(0, 1'b0, 17'h00200, 8'h00);
    set_req(1, 1'b1, 17'h00100, 8'h3C);
    for (int w = 0; w < 4; w++) begin
      run_window(6 + w, 1'b1, '0, 1'b0, DW'($urandom), w[0]);
      check("t3_order", 32'(pending[w % 2]), 32'd0);
      if (!pending[0]) set_req(0, 1'b0, 17'h00200, 8'h00);
      if (!pending[1]) set_req(1, 1'b1, 17'h00100, 8'h3C);
    end

    // Request rising one cycle after select waits for the next slot
    pulse_reset(1'b1);
    run_window(6, 1'b1, 3'b010, 1'b0, DW'($urandom), 1'b0);
    check("t4_pending", 32'(pending[1]), 32'd1);
    run_window(6, 1'b1, '0, 1'b0, DW'($urandom), 1'b0);

    // Select dropped before enable aborts the slot
    set_req(0, 1'b0, 17'h1ABCD, 8'h00);
    run_window(6, 1'b0, '0, 1'b0, DW'($urandom), 1'b0);
    check("t5_pending", 32'(pending[0]), 32'd1);
    run_window(6, 1'b1, '0, 1'b0, 8'h5A, 1'b0);

    // Reset while waiting for enable
    set_req(2, 1'b0, 17'h00777, 8'h00);
    set_req(0, 1'b0, 17'h00042, 8'h00);
    run_window(7, 1'b1, '0, 1'b1, DW'($urandom), 1'b0);
    run_window(7, 1'b1, '0, 1'b0, 8'hC3, 1'b0);
    check("t6_first_after_rst", 32'(pending[0]), 32'd0);
    run_window(7, 1'b1, '0, 1'b0, 8'h3C, 1'b0);

    // Randomized windows
    for (int w = 0; w < 80; w++) begin
      prep_random();
      run_window($urandom_range(5, 9), $urandom_range(0, 6) != 0, N'($urandom),
                 $urandom_range(0, 19) == 0, DW'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
